// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC cosine chain and its float packer.
package cordic_pkg;

  localparam int unsigned FRAC_BITS = 30;
  localparam int unsigned EXP_BIAS  = 127;
  localparam int unsigned MANT_BITS = 23;

  // CORDIC gain compensation K in Q2.30.
  localparam logic [31:0] K_FIXED = 32'h26DD3B80;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StRound,
    StDone
  } packer_state_t;

endpackage

// File: rtl/float_round.sv
// Combinational pack of a normalized magnitude into IEEE-754 single precision.
// Round-to-nearest-even when FLOAT_PACKER_RNE_EN is defined, truncation otherwise.
module float_round
  import cordic_pkg::*;
#(
  parameter int unsigned FRAC_BITS = cordic_pkg::FRAC_BITS,
  parameter int unsigned W         = 32
) (
  input  logic [W-1:0] mag,
  input  logic [5:0]   shift,
  input  logic         sign,
  output logic [31:0]  result
);

  localparam logic [8:0] ExpBase = 9'(W - 1 - FRAC_BITS + EXP_BIAS);

  logic [MANT_BITS-1:0] mant;
  logic [MANT_BITS-1:0] mant_final;
  logic [8:0]           exp_raw;
  logic [8:0]           exp_final;
  logic                 unused_bits;

  assign mant    = mag[W-2 -: MANT_BITS];
  assign exp_raw = ExpBase - {3'b000, shift};

`ifdef FLOAT_PACKER_RNE_EN
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [MANT_BITS:0]   mant_rnd;

  assign guard    = mag[W-2-MANT_BITS];
  assign sticky   = |mag[W-3-MANT_BITS:0];
  assign round_up = guard && (sticky || mant[0]);
  assign mant_rnd = {1'b0, mant} + (MANT_BITS + 1)'(round_up);
  // A carry out leaves the low bits at zero, so only the exponent needs bumping.
  assign mant_final = mant_rnd[MANT_BITS-1:0];
  assign exp_final  = exp_raw + 9'(mant_rnd[MANT_BITS]);
  assign unused_bits = mag[W-1] ^ exp_final[8];
`else
  assign mant_final  = mant;
  assign exp_final   = exp_raw;
  assign unused_bits = mag[W-1] ^ exp_final[8] ^ (^mag[W-2-MANT_BITS:0]);
`endif

  always_comb begin
    result = {sign, exp_final[7:0], mant_final};
    if (mag == '0) begin
      result = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/float_packer.sv
// Sequential Q2.30 fixed-point to IEEE-754 single packer with one-bit-per-cycle normalization.
// Optional round-to-nearest-even via FLOAT_PACKER_RNE_EN (see float_round).
module float_packer
  import cordic_pkg::*;
#(
  parameter int unsigned FRAC_BITS = cordic_pkg::FRAC_BITS,
  parameter int unsigned W         = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_fixed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_float
);

  packer_state_t state;
  logic          sign_q;
  logic [W-1:0]  mag_q;
  logic [5:0]    shift_q;
  logic [31:0]   packed_float;

  float_round #(
    .FRAC_BITS(FRAC_BITS),
    .W        (W)
  ) u_float_round (
    .mag   (mag_q),
    .shift (shift_q),
    .sign  (sign_q),
    .result(packed_float)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_float <= '0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      shift_q   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid && in_ready) begin
            sign_q   <= in_fixed[W-1];
            // Negating the most negative value wraps back to itself, which is its true magnitude.
            mag_q    <= in_fixed[W-1] ? -in_fixed : in_fixed;
            shift_q  <= '0;
            in_ready <= 1'b0;
            state    <= StNorm;
          end
        end
        StNorm: begin
          if (!mag_q[W-1] && (mag_q != '0)) begin
            mag_q   <= mag_q << 1;
            shift_q <= shift_q + 6'd1;
          end else begin
            state <= StRound;
          end
        end
        StRound: begin
          out_float <= packed_float;
          out_valid <= 1'b1;
          state     <= StDone;
        end
        StDone: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_float_packer.sv
// Directed self-checking bench for float_packer; expectations follow FLOAT_PACKER_RNE_EN.
module tb_float_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_fixed = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_float;

  int checks = 0;
  int failures = 0;

  float_packer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_fixed (in_fixed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_float(out_float)
  );

  always #5 clk = ~clk;

  // Accept x and wait (bounded) for out_valid; lat counts edges after the accept edge.
  task automatic run(input logic [31:0] x, output logic [31:0] f, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_fixed = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_fixed = '0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    f = out_float;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_float !== 32'h0) begin failures++; $display("FAIL reset_out_float got=%h exp=0", out_float); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_values();
    logic [31:0] vin  [5] = '{32'h4000_0000, 32'h26DD_3B80, 32'hC000_0000, 32'h8000_0000,
                              32'h0000_0000};
    logic [31:0] vexp [5] = '{32'h3F80_0000, 32'h3F1B_74EE, 32'hBF80_0000, 32'hC000_0000,
                              32'h0000_0000};
    int          vlat [5] = '{3, 4, 3, 2, 2};
    logic [31:0] f;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run(vin[i], f, lat);
      checks++;
      if (f !== vexp[i]) begin
        failures++; $display("FAIL value_%h got=%h exp=%h", vin[i], f, vexp[i]);
      end
      checks++;
      if (lat != vlat[i]) begin
        failures++; $display("FAIL latency_%h got=%0d exp=%0d", vin[i], lat, vlat[i]);
      end
      drain();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++; $display("FAIL return_idle_%h valid=%b ready=%b exp valid=0 ready=1",
                             vin[i], out_valid, in_ready);
      end
    end
  endtask

  task automatic test_smallest();
    logic [31:0] f;
    int lat;
    run(32'h0000_0001, f, lat);
    checks++;
    if (f !== 32'h3080_0000) begin failures++; $display("FAIL smallest got=%h exp=30800000", f); end
    checks++;
    if (lat != 33) begin failures++; $display("FAIL smallest_latency got=%0d exp=33", lat); end
    drain();
  endtask

  task automatic test_rounding();
    logic [31:0] vin [3] = '{32'h7FFF_FFFF, 32'h4000_0040, 32'h4000_00C0};
`ifdef FLOAT_PACKER_RNE_EN
    logic [31:0] vexp [3] = '{32'h4000_0000, 32'h3F80_0000, 32'h3F80_0002};
`else
    logic [31:0] vexp [3] = '{32'h3FFF_FFFF, 32'h3F80_0000, 32'h3F80_0001};
`endif
    logic [31:0] f;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run(vin[i], f, lat);
      checks++;
      if (f !== vexp[i]) begin
        failures++; $display("FAIL round_%h got=%h exp=%h", vin[i], f, vexp[i]);
      end
      checks++;
      if (lat != 3) begin failures++; $display("FAIL round_latency_%h got=%0d exp=3", vin[i], lat); end
      drain();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] f;
    int lat;
    int bad = 0;
    run(32'hC000_0000, f, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (out_float !== 32'hBF80_0000 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL backpressure_hold float=%h valid=%b ready=%b exp=bf800000/1/0",
                           out_float, out_valid, in_ready);
    end
    drain();
  endtask

  task automatic test_busy_ignore();
    logic [31:0] f;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_fixed = 32'h0000_0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_fixed = 32'h4000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    in_fixed = '0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    f = out_float;
    checks++;
    if (f !== 32'h3080_0000) begin failures++; $display("FAIL busy_ignore got=%h exp=30800000", f); end
    drain();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL busy_no_second got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] f;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_fixed = 32'h0000_0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_float !== 32'h0) begin
      failures++; $display("FAIL reset_mid ready=%b valid=%b float=%h exp=1/0/00000000",
                           in_ready, out_valid, out_float);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(cordic_pkg::K_FIXED, f, lat);
    checks++;
    if (f !== 32'h3F1B_74EE) begin failures++; $display("FAIL after_reset got=%h exp=3f1b74ee", f); end
    checks++;
    if (lat != 4) begin failures++; $display("FAIL after_reset_latency got=%0d exp=4", lat); end
    drain();
  endtask

  initial begin
    test_reset();
    test_values();
    test_smallest();
    test_rounding();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
